// File: rtl/score_keeper.sv
// Game controller: edge-detects start/hit/miss and keeps a BCD score, lives, a high score and the difficulty level.
// Latency: an event's effect is on the outputs after the clk edge that first samples the input high. All outputs are registered.
// Backpressure: none. The block accepts an event on every cycle, and holding an input high counts as one event.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   start, hit, miss          level inputs, each rising level is one event
//   enable, difficulty        drive the frequency generator
//   score_tens/ones, hi_tens/ones   BCD current and high score
//   lives, game_over          remaining lives, and the OVER state flag
module score_keeper #(
    parameter int LIVES      = 3,
    parameter int LEVEL_STEP = 5,
    parameter int START_DIFF = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic       enable,
    output logic [2:0] difficulty,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [3:0] hi_tens,
    output logic [3:0] hi_ones,
    output logic [3:0] lives,
    output logic       game_over
);

    localparam logic [3:0] LIVES_V = 4'(LIVES);
    localparam logic [3:0] STEP_V  = 4'(LEVEL_STEP);
    localparam logic [2:0] DIFF_V  = 3'(START_DIFF);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t     state;
    logic       start_q, hit_q, miss_q;
    logic [3:0] level_cnt;

    logic start_ev, hit_ev, miss_ev;
    logic score_gt_hi;
    logic score_max;

    assign start_ev = start & ~start_q;
    assign hit_ev   = hit   & ~hit_q;
    assign miss_ev  = miss  & ~miss_q;

    // BCD digits keep their order when the two digits are concatenated,
    // so a plain binary compare of the 8-bit values is correct.
    assign score_gt_hi = {score_tens, score_ones} > {hi_tens, hi_ones};
    assign score_max   = (score_tens == 4'd9) && (score_ones == 4'd9);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            enable     <= 1'b0;
            game_over  <= 1'b0;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            hi_tens    <= 4'd0;
            hi_ones    <= 4'd0;
            lives      <= 4'd0;
            difficulty <= DIFF_V;
            level_cnt  <= 4'd0;
            start_q    <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            start_q <= start;
            hit_q   <= hit;
            miss_q  <= miss;
            case (state)
                IDLE, OVER: begin
                    // Hit and miss events are ignored outside PLAY.
                    if (start_ev) begin
                        state      <= PLAY;
                        enable     <= 1'b1;
                        game_over  <= 1'b0;
                        score_tens <= 4'd0;
                        score_ones <= 4'd0;
                        lives      <= LIVES_V;
                        difficulty <= DIFF_V;
                        level_cnt  <= 4'd0;
                    end
                end
                PLAY: begin
                    if (miss_ev) begin
                        // A miss has priority. A hit on the same edge is discarded.
                        lives <= lives - 4'd1;
                        if (lives == 4'd1) begin
                            state     <= OVER;
                            enable    <= 1'b0;
                            game_over <= 1'b1;
                            if (score_gt_hi) begin
                                hi_tens <= score_tens;
                                hi_ones <= score_ones;
                            end
                        end
                    end else if (hit_ev) begin
                        if (!score_max) begin
                            if (score_ones == 4'd9) begin
                                score_ones <= 4'd0;
                                score_tens <= score_tens + 4'd1;
                            end else begin
                                score_ones <= score_ones + 4'd1;
                            end
                        end
                        // The level counter keeps counting when the score is saturated.
                        if (level_cnt + 4'd1 == STEP_V) begin
                            level_cnt <= 4'd0;
                            if (difficulty != 3'd7)
                                difficulty <= difficulty + 3'd1;
                        end else begin
                            level_cnt <= level_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    enable    <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper. It runs directed game scenarios and then random
// stimulus, and compares every output against a reference model.
// The model holds the score as a plain integer and the game phase as a small integer.
module tb_score_keeper;

    localparam int LIVES      = 3;
    localparam int LEVEL_STEP = 5;
    localparam int START_DIFF = 0;

    logic       clk;
    logic       rst;
    logic       start;
    logic       hit;
    logic       miss;
    logic       enable;
    logic [2:0] difficulty;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [3:0] hi_tens;
    logic [3:0] hi_ones;
    logic [3:0] lives;
    logic       game_over;

    score_keeper #(
        .LIVES(LIVES), .LEVEL_STEP(LEVEL_STEP), .START_DIFF(START_DIFF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss),
        .enable(enable), .difficulty(difficulty),
        .score_tens(score_tens), .score_ones(score_ones),
        .hi_tens(hi_tens), .hi_ones(hi_ones),
        .lives(lives), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state. Phase 0 is idle, 1 is playing, 2 is game over.
    int m_phase, m_score, m_hi, m_lives, m_diff, m_hits_in_level;
    bit m_prev_start, m_prev_hit, m_prev_miss;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit h, input bit m);
        bit s_ev, h_ev, m_ev;
        if (!r) begin
            m_phase = 0; m_score = 0; m_hi = 0; m_lives = 0;
            m_diff = START_DIFF; m_hits_in_level = 0;
            m_prev_start = 0; m_prev_hit = 0; m_prev_miss = 0;
            return;
        end
        s_ev = s && !m_prev_start;
        h_ev = h && !m_prev_hit;
        m_ev = m && !m_prev_miss;
        m_prev_start = s; m_prev_hit = h; m_prev_miss = m;
        if (m_phase != 1) begin
            if (s_ev) begin
                m_phase = 1; m_score = 0; m_lives = LIVES;
                m_diff = START_DIFF; m_hits_in_level = 0;
            end
        end else if (m_ev) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) begin
                m_phase = 2;
                if (m_score > m_hi) m_hi = m_score;
            end
        end else if (h_ev) begin
            if (m_score < 99) m_score = m_score + 1;
            m_hits_in_level = m_hits_in_level + 1;
            if (m_hits_in_level == LEVEL_STEP) begin
                m_hits_in_level = 0;
                if (m_diff < 7) m_diff = m_diff + 1;
            end
        end
    endtask

    task automatic check_all();
        check("enable",     int'(enable),     (m_phase == 1) ? 1 : 0);
        check("game_over",  int'(game_over),  (m_phase == 2) ? 1 : 0);
        check("score_tens", int'(score_tens), m_score / 10);
        check("score_ones", int'(score_ones), m_score % 10);
        check("hi_tens",    int'(hi_tens),    m_hi / 10);
        check("hi_ones",    int'(hi_ones),    m_hi % 10);
        check("lives",      int'(lives),      m_lives);
        check("difficulty", int'(difficulty), m_diff);
    endtask

    // Drives the inputs away from the active edge and runs one clock.
    // It then updates the model and compares all outputs 1 ns after the edge.
    task automatic step(input bit r, input bit s, input bit h, input bit m);
        @(negedge clk);
        rst = r; start = s; hit = h; miss = m;
        @(posedge clk);
        #1;
        model_edge(r, s, h, m);
        check_all();
    endtask

    task automatic pulse_hit();
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
    endtask

    task automatic pulse_miss();
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
    endtask

    task automatic new_game();
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
    endtask

    int sc;

    initial begin
        rst = 0; start = 0; hit = 0; miss = 0;
        model_edge(0, 0, 0, 0);

        // Reset.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("rst_enable", int'(enable), 0);
        check("rst_lives", int'(lives), 0);
        check("rst_diff", int'(difficulty), START_DIFF);

        // Start a game, score 12 hits, then hold hit high for 10 cycles.
        new_game();
        check("start_enable", int'(enable), 1);
        repeat (12) pulse_hit();
        check("twelve_score", int'({score_tens, score_ones}), 8'h12);
        check("twelve_diff", int'(difficulty), 2);
        check("twelve_lives", int'(lives), 3);
        repeat (10) step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        check("hold_score", int'({score_tens, score_ones}), 8'h13);

        // Three misses end the game. The score 13 becomes the high score.
        repeat (3) pulse_miss();
        check("over_flag", int'(game_over), 1);
        check("over_hi", int'({hi_tens, hi_ones}), 8'h13);
        repeat (3) pulse_hit();
        check("over_score_frozen", int'({score_tens, score_ones}), 8'h13);

        // A start and a hit on the same edge in OVER begin a new game at 00.
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        check("start_hit_score", int'({score_tens, score_ones}), 8'h00);

        // Score 09 -> 10 carry, then saturate at 99 with difficulty capped at 7.
        repeat (9) pulse_hit();
        check("nine", int'({score_tens, score_ones}), 8'h09);
        pulse_hit();
        check("carry_ten", int'({score_tens, score_ones}), 8'h10);
        repeat (95) pulse_hit();
        check("sat_99", int'({score_tens, score_ones}), 8'h99);
        check("diff_cap", int'(difficulty), 7);

        // Hit and miss on the same edge with 2 lives: the miss wins.
        pulse_miss();
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);
        check("hm_lives", int'(lives), 1);
        check("hm_score", int'({score_tens, score_ones}), 8'h99);

        // A reset in the middle of a game returns everything to reset values.
        new_game();
        repeat (7) pulse_hit();
        step(0, 0, 0, 0);
        check("midrst_hi", int'({hi_tens, hi_ones}), 8'h00);
        check("midrst_enable", int'(enable), 0);

        // High score 12, then a later game that scores only 5.
        new_game();
        repeat (12) pulse_hit();
        repeat (3) pulse_miss();
        new_game();
        repeat (5) pulse_hit();
        repeat (3) pulse_miss();
        check("hi_kept", int'({hi_tens, hi_ones}), 8'h12);

        // Random phase.
        for (int i = 0; i < 4000; i++) begin
            sc = $urandom_range(0, 999);
            step((sc < 5) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 6),
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
